wb_traffic_initiator: RTL and testbench

Parametrised Wishbone initiator traffic generator with self-checking readback, used in interconnect benches (formal and simulation) for any NxM fabric. It issues a programmable number of write and read transactions, rotating round-robin across targets, and compares read data against the expected pattern. It reports transaction count, mismatch count, and sticky timeout and protocol-error flags.

---
 rtl/wb_traffic_initiator_if.sv | 30 +++
 rtl/wb_traffic_initiator.sv | 201 ++++++++++++++++++++
 tb/tb_wb_traffic_initiator.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_traffic_initiator_if.sv
// Wishbone initiator-side bus bundle used by wb_traffic_initiator.
// Signals:
//   i_adr, i_dat_w, i_cyc, i_stb, i_we, i_sel : initiator -> fabric
//   i_dat_r, i_ack, i_err                     : fabric -> initiator
interface wb_traffic_initiator_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned SEL_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] i_adr;
  logic [DATA_WIDTH-1:0] i_dat_w;
  logic [DATA_WIDTH-1:0] i_dat_r;
  logic                  i_cyc;
  logic                  i_stb;
  logic                  i_we;
  logic [SEL_W-1:0]      i_sel;
  logic                  i_ack;
  logic                  i_err;

  modport master (
    output i_adr, i_dat_w, i_cyc, i_stb, i_we, i_sel,
    input  i_dat_r, i_ack, i_err
  );

  modport slave (
    input  i_adr, i_dat_w, i_cyc, i_stb, i_we, i_sel,
    output i_dat_r, i_ack, i_err
  );
endinterface

// File: rtl/wb_traffic_initiator.sv
// Wishbone traffic generator: issues N_TXN writes and N_TXN reads, rotating
// round-robin over N_TARGETS, and checks read data against the write pattern.
// Ports:
//   clock, reset   : clock, synchronous active-high reset
//   bus            : Wishbone initiator bundle (master modport)
//   start          : single-cycle run request (ignored while busy)
//   busy, done     : run in progress / sticky run-complete
//   txn_count      : completed transactions (wraps)
//   err_count      : read mismatches plus error responses (saturates)
//   timeout        : sticky, a transaction was aborted waiting for ack/err
//   protocol_err   : sticky, ack/err while idle or ack and err together
module wb_traffic_initiator #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_TARGETS  = 2,
  parameter int unsigned ID         = 0,
  parameter int unsigned N_TXN      = 16,
  parameter int unsigned MODE       = 0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  wb_traffic_initiator_if.master bus,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           txn_count,
  output logic [7:0]            err_count,
  output logic                  timeout,
  output logic                  protocol_err
);
  localparam int unsigned SEL_W  = DATA_WIDTH / 8;
  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [7:0]        LAST_K    = 8'(N_TXN - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP, S_DONE} state_t;

  state_t            state;
  logic [7:0]        k;
  logic              phase_rd;
  logic [WAIT_W-1:0] wait_cnt;

  logic [7:0] adv_k;
  logic       adv_rd;
  logic       adv_last;
  logic [7:0] l_k;
  logic       l_rd;

  // Target select in the top nibble, initiator ID below it, index in the low byte.
  function automatic logic [ADDR_WIDTH-1:0] make_adr(input logic [7:0] kk);
    logic [ADDR_WIDTH-1:0] a;
    a = '0;
    a[ADDR_WIDTH-1 -: 4] = 4'(32'(kk) % N_TARGETS);
    a[ADDR_WIDTH-5 -: 4] = 4'(ID);
    a[7:0]               = kk;
    return a;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [7:0] kk);
    logic [DATA_WIDTH-1:0] p;
    p       = '0;
    p[15:0] = {4'(ID), 4'hA, kk};
    return p;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Index/phase sequencing applied when leaving GAP.
  always_comb begin
    adv_k    = k;
    adv_rd   = phase_rd;
    adv_last = 1'b0;
    if (MODE == 0) begin
      if (k == LAST_K) begin
        adv_k    = 8'd0;
        adv_rd   = 1'b1;
        adv_last = phase_rd;
      end else begin
        adv_k = k + 8'd1;
      end
    end else begin
      if (!phase_rd) begin
        adv_rd = 1'b1;
      end else if (k == LAST_K) begin
        adv_last = 1'b1;
      end else begin
        adv_k  = k + 8'd1;
        adv_rd = 1'b0;
      end
    end
  end

  // Transaction to launch next: first write of a run, or the advanced index.
  always_comb begin
    l_k  = 8'd0;
    l_rd = 1'b0;
    if (state == S_GAP) begin
      l_k  = adv_k;
      l_rd = adv_rd;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      k            <= 8'd0;
      phase_rd     <= 1'b0;
      wait_cnt     <= '0;
      bus.i_adr    <= '0;
      bus.i_dat_w  <= '0;
      bus.i_cyc    <= 1'b0;
      bus.i_stb    <= 1'b0;
      bus.i_we     <= 1'b0;
      bus.i_sel    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      txn_count    <= 16'd0;
      err_count    <= 8'd0;
      timeout      <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            done         <= 1'b0;
            txn_count    <= 16'd0;
            err_count    <= 8'd0;
            timeout      <= 1'b0;
            protocol_err <= 1'b0;
            busy         <= 1'b1;
            k            <= l_k;
            phase_rd     <= l_rd;
            wait_cnt     <= '0;
            bus.i_cyc    <= 1'b1;
            bus.i_stb    <= 1'b1;
            bus.i_sel    <= {SEL_W{1'b1}};
            bus.i_we     <= ~l_rd;
            bus.i_adr    <= make_adr(l_k);
            bus.i_dat_w  <= l_rd ? '0 : pattern(l_k);
            state        <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (bus.i_err) begin
            // err wins over a simultaneous ack, which is itself a protocol fault
            txn_count <= txn_count + 16'd1;
            err_count <= sat_inc(err_count);
            if (bus.i_ack) protocol_err <= 1'b1;
            bus.i_cyc <= 1'b0;
            bus.i_stb <= 1'b0;
            bus.i_sel <= '0;
            state     <= S_GAP;
          end else if (bus.i_ack) begin
            txn_count <= txn_count + 16'd1;
            if (phase_rd && (bus.i_dat_r != pattern(k))) err_count <= sat_inc(err_count);
            bus.i_cyc <= 1'b0;
            bus.i_stb <= 1'b0;
            bus.i_sel <= '0;
            state     <= S_GAP;
          end else if (wait_cnt == LAST_WAIT) begin
            // abort: the cycle has now been held TIMEOUT cycles
            timeout   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            bus.i_cyc <= 1'b0;
            bus.i_stb <= 1'b0;
            bus.i_sel <= '0;
            state     <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_GAP: begin
          if (adv_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            k           <= l_k;
            phase_rd    <= l_rd;
            wait_cnt    <= '0;
            bus.i_cyc   <= 1'b1;
            bus.i_stb   <= 1'b1;
            bus.i_sel   <= {SEL_W{1'b1}};
            bus.i_we    <= ~l_rd;
            bus.i_adr   <= make_adr(l_k);
            bus.i_dat_w <= l_rd ? '0 : pattern(l_k);
            state       <= S_ACTIVE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Stray termination while no cycle is open; placed last so it wins over a start clear.
      if ((bus.i_ack || bus.i_err) && !bus.i_cyc) protocol_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_traffic_initiator.sv
// Directed bench for wb_traffic_initiator: two instances (MODE 0 and MODE 1)
// share one responder driven from a table of per-transaction records.
`timescale 1ns/1ps
module tb_wb_traffic_initiator;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset    = 1'b1;
  logic        tb_start = 1'b0;
  logic        tb_ack   = 1'b0;
  logic        tb_err   = 1'b0;
  logic [31:0] tb_dat_r = '0;
  logic        sel_b    = 1'b0;

  int unsigned cyc_ctr = 0;
  int unsigned t0      = 0;
  int          checks  = 0;
  int          errors  = 0;

  always @(posedge clock) cyc_ctr <= cyc_ctr + 1;

  wb_traffic_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  wb_traffic_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

  assign bus_a.i_ack   = tb_ack & ~sel_b;
  assign bus_a.i_err   = tb_err & ~sel_b;
  assign bus_a.i_dat_r = tb_dat_r;
  assign bus_b.i_ack   = tb_ack & sel_b;
  assign bus_b.i_err   = tb_err & sel_b;
  assign bus_b.i_dat_r = tb_dat_r;

  logic        busy_a, done_a, tmo_a, perr_a;
  logic [15:0] txn_a;
  logic [7:0]  err_a;
  logic        busy_b, done_b, tmo_b, perr_b;
  logic [15:0] txn_b;
  logic [7:0]  err_b;

  wb_traffic_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_TARGETS(2), .ID(1),
    .N_TXN(4), .MODE(0), .TIMEOUT(8)
  ) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a), .start(tb_start & ~sel_b),
    .busy(busy_a), .done(done_a), .txn_count(txn_a), .err_count(err_a),
    .timeout(tmo_a), .protocol_err(perr_a)
  );

  wb_traffic_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_TARGETS(3), .ID(5),
    .N_TXN(3), .MODE(1), .TIMEOUT(255)
  ) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b), .start(tb_start & sel_b),
    .busy(busy_b), .done(done_b), .txn_count(txn_b), .err_count(err_b),
    .timeout(tmo_b), .protocol_err(perr_b)
  );

  // View of whichever instance is currently selected
  logic        m_cyc, m_stb, m_we, m_busy, m_done, m_tmo, m_perr;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_dat_w;
  logic [15:0] m_txn;
  logic [7:0]  m_err;
  assign m_cyc   = sel_b ? bus_b.i_cyc   : bus_a.i_cyc;
  assign m_stb   = sel_b ? bus_b.i_stb   : bus_a.i_stb;
  assign m_we    = sel_b ? bus_b.i_we    : bus_a.i_we;
  assign m_sel   = sel_b ? bus_b.i_sel   : bus_a.i_sel;
  assign m_adr   = sel_b ? bus_b.i_adr   : bus_a.i_adr;
  assign m_dat_w = sel_b ? bus_b.i_dat_w : bus_a.i_dat_w;
  assign m_busy  = sel_b ? busy_b : busy_a;
  assign m_done  = sel_b ? done_b : done_a;
  assign m_tmo   = sel_b ? tmo_b  : tmo_a;
  assign m_perr  = sel_b ? perr_b : perr_a;
  assign m_txn   = sel_b ? txn_b  : txn_a;
  assign m_err   = sel_b ? err_b  : err_a;

  // rsp: 0 = ack, 1 = err, 2 = ack and err together
  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat_w;
    int          waits;
    logic [31:0] rdata;
    logic [1:0]  rsp;
    logic        stray;
    int          gap;
  } vec_t;

  vec_t vecs [36];

  function automatic vec_t mk(input logic [31:0] adr, input logic we, input logic [31:0] dw,
                              input int waits, input logic [31:0] rd, input logic [1:0] rsp,
                              input logic stray, input int gap);
    vec_t v;
    v.adr = adr; v.we = we; v.dat_w = dw; v.waits = waits;
    v.rdata = rd; v.rsp = rsp; v.stray = stray; v.gap = gap;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_start();
    tb_start = 1'b1;
    @(negedge clock);
    tb_start = 1'b0;
    t0 = cyc_ctr;
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      int idle;
      idle = 0;
      while (!m_cyc && idle < 40) begin
        @(negedge clock);
        idle++;
      end
      chk("gap_len", 32'(idle), 32'(vecs[i].gap));
      chk("stb", 32'(m_stb), 32'd1);
      chk("sel", 32'(m_sel), 32'hF);
      chk("adr", m_adr, vecs[i].adr);
      chk("we", 32'(m_we), 32'(vecs[i].we));
      chk("dat_w", m_dat_w, vecs[i].dat_w);
      for (int w = 0; w < vecs[i].waits; w++) @(negedge clock);
      if (vecs[i].waits > 0) begin
        chk("hold_cyc", 32'(m_cyc), 32'd1);
        chk("hold_adr", m_adr, vecs[i].adr);
      end
      tb_dat_r = vecs[i].rdata;
      tb_ack   = (vecs[i].rsp != 2'd1);
      tb_err   = (vecs[i].rsp != 2'd0);
      @(negedge clock);
      tb_ack   = 1'b0;
      tb_err   = 1'b0;
      tb_dat_r = '0;
      chk("cyc_drop", 32'(m_cyc), 32'd0);
      if (vecs[i].stray) begin
        tb_ack = 1'b1;
        @(negedge clock);
        tb_ack = 1'b0;
      end
    end
  endtask

  task automatic wait_done(output int unsigned dt);
    int n;
    n = 0;
    while (!m_done && n < 60) begin
      @(negedge clock);
      n++;
    end
    dt = cyc_ctr - t0;
    chk("done", 32'(m_done), 32'd1);
    chk("busy_end", 32'(m_busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cyc"}, 32'(m_cyc), 32'd0);
    chk({tag, "_stb"}, 32'(m_stb), 32'd0);
    chk({tag, "_we"}, 32'(m_we), 32'd0);
    chk({tag, "_sel"}, 32'(m_sel), 32'd0);
    chk({tag, "_adr"}, m_adr, 32'd0);
    chk({tag, "_dat_w"}, m_dat_w, 32'd0);
    chk({tag, "_busy"}, 32'(m_busy), 32'd0);
    chk({tag, "_done"}, 32'(m_done), 32'd0);
    chk({tag, "_txn"}, 32'(m_txn), 32'd0);
    chk({tag, "_err"}, 32'(m_err), 32'd0);
    chk({tag, "_tmo"}, 32'(m_tmo), 32'd0);
    chk({tag, "_perr"}, 32'(m_perr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned dt;
    int n;

    // A (ID 1, 2 targets, MODE 0): zero-wait memory run
    vecs[0]  = mk(32'h0100_0000, 1'b1, 32'h0000_1A00, 0, 32'h0,         2'd0, 1'b0, 0);
    vecs[1]  = mk(32'h1100_0001, 1'b1, 32'h0000_1A01, 0, 32'h0,         2'd0, 1'b0, 1);
    vecs[2]  = mk(32'h0100_0002, 1'b1, 32'h0000_1A02, 0, 32'h0,         2'd0, 1'b0, 1);
    vecs[3]  = mk(32'h1100_0003, 1'b1, 32'h0000_1A03, 0, 32'h0,         2'd0, 1'b0, 1);
    vecs[4]  = mk(32'h0100_0000, 1'b0, 32'h0,         0, 32'h0000_1A00, 2'd0, 1'b0, 1);
    vecs[5]  = mk(32'h1100_0001, 1'b0, 32'h0,         0, 32'h0000_1A01, 2'd0, 1'b0, 1);
    vecs[6]  = mk(32'h0100_0002, 1'b0, 32'h0,         0, 32'h0000_1A02, 2'd0, 1'b0, 1);
    vecs[7]  = mk(32'h1100_0003, 1'b0, 32'h0,         0, 32'h0000_1A03, 2'd0, 1'b0, 1);
    // B (ID 5, 3 targets, MODE 1): two wait states each
    vecs[8]  = mk(32'h0500_0000, 1'b1, 32'h0000_5A00, 2, 32'h0,         2'd0, 1'b0, 0);
    vecs[9]  = mk(32'h0500_0000, 1'b0, 32'h0,         2, 32'h0000_5A00, 2'd0, 1'b0, 1);
    vecs[10] = mk(32'h1500_0001, 1'b1, 32'h0000_5A01, 2, 32'h0,         2'd0, 1'b0, 1);
    vecs[11] = mk(32'h1500_0001, 1'b0, 32'h0,         2, 32'h0000_5A01, 2'd0, 1'b0, 1);
    vecs[12] = mk(32'h2500_0002, 1'b1, 32'h0000_5A02, 2, 32'h0,         2'd0, 1'b0, 1);
    vecs[13] = mk(32'h2500_0002, 1'b0, 32'h0,         2, 32'h0000_5A02, 2'd0, 1'b0, 1);
    // A: read of k=2 returns corrupted data
    vecs[14] = mk(32'h0100_0000, 1'b1, 32'h0000_1A00, 1, 32'h0,         2'd0, 1'b0, 0);
    vecs[15] = mk(32'h1100_0001, 1'b1, 32'h0000_1A01, 0, 32'h0,         2'd0, 1'b0, 1);
    vecs[16] = mk(32'h0100_0002, 1'b1, 32'h0000_1A02, 3, 32'h0,         2'd0, 1'b0, 1);
    vecs[17] = mk(32'h1100_0003, 1'b1, 32'h0000_1A03, 0, 32'h0,         2'd0, 1'b0, 1);
    vecs[18] = mk(32'h0100_0000, 1'b0, 32'h0,         1, 32'h0000_1A00, 2'd0, 1'b0, 1);
    vecs[19] = mk(32'h1100_0001, 1'b0, 32'h0,         0, 32'h0000_1A01, 2'd0, 1'b0, 1);
    vecs[20] = mk(32'h0100_0002, 1'b0, 32'h0,         1, 32'h0000_1AFF, 2'd0, 1'b0, 1);
    vecs[21] = mk(32'h1100_0003, 1'b0, 32'h0,         0, 32'h0000_1A03, 2'd0, 1'b0, 1);
    // B: stray ack in the gap after W0, then an error response on R0
    vecs[22] = mk(32'h0500_0000, 1'b1, 32'h0000_5A00, 0, 32'h0,         2'd0, 1'b1, 0);
    vecs[23] = mk(32'h0500_0000, 1'b0, 32'h0,         0, 32'h0,         2'd1, 1'b0, 0);
    vecs[24] = mk(32'h1500_0001, 1'b1, 32'h0000_5A01, 0, 32'h0,         2'd0, 1'b0, 1);
    vecs[25] = mk(32'h1500_0001, 1'b0, 32'h0,         0, 32'h0000_5A01, 2'd0, 1'b0, 1);
    vecs[26] = mk(32'h2500_0002, 1'b1, 32'h0000_5A02, 0, 32'h0,         2'd0, 1'b0, 1);
    vecs[27] = mk(32'h2500_0002, 1'b0, 32'h0,         0, 32'h0000_5A02, 2'd0, 1'b0, 1);
    // A: ack and err together on W1
    vecs[28] = mk(32'h0100_0000, 1'b1, 32'h0000_1A00, 0, 32'h0,         2'd0, 1'b0, 0);
    vecs[29] = mk(32'h1100_0001, 1'b1, 32'h0000_1A01, 1, 32'h0,         2'd2, 1'b0, 1);
    vecs[30] = mk(32'h0100_0002, 1'b1, 32'h0000_1A02, 0, 32'h0,         2'd0, 1'b0, 1);
    vecs[31] = mk(32'h1100_0003, 1'b1, 32'h0000_1A03, 0, 32'h0,         2'd0, 1'b0, 1);
    vecs[32] = mk(32'h0100_0000, 1'b0, 32'h0,         0, 32'h0000_1A00, 2'd0, 1'b0, 1);
    vecs[33] = mk(32'h1100_0001, 1'b0, 32'h0,         0, 32'h0000_1A01, 2'd0, 1'b0, 1);
    vecs[34] = mk(32'h0100_0002, 1'b0, 32'h0,         0, 32'h0000_1A02, 2'd0, 1'b0, 1);
    vecs[35] = mk(32'h1100_0003, 1'b0, 32'h0,         0, 32'h0000_1A03, 2'd0, 1'b0, 1);

    // Reset state
    repeat (3) @(negedge clock);
    sel_b = 1'b0;
    chk_all_zero("rst_a");
    sel_b = 1'b1;
    chk_all_zero("rst_b");
    reset = 1'b0;
    @(negedge clock);

    // Run 1: MODE 0 zero-wait, 8 transactions in 16 cycles
    sel_b = 1'b0;
    do_start();
    chk("busy_run1", 32'(m_busy), 32'd1);
    run_vecs(0, 7);
    wait_done(dt);
    chk("run1_cycles", dt, 32'd16);
    chk("run1_txn", 32'(m_txn), 32'd8);
    chk("run1_err", 32'(m_err), 32'd0);
    chk("run1_tmo", 32'(m_tmo), 32'd0);
    chk("run1_perr", 32'(m_perr), 32'd0);

    // Run 2: MODE 1 with two wait states, 4 cycles per transaction
    sel_b = 1'b1;
    @(negedge clock);
    do_start();
    run_vecs(8, 13);
    wait_done(dt);
    chk("run2_cycles", dt, 32'd24);
    chk("run2_txn", 32'(m_txn), 32'd6);
    chk("run2_err", 32'(m_err), 32'd0);

    // Run 3: corrupted read on k=2; start from DONE clears counters
    sel_b = 1'b0;
    @(negedge clock);
    chk("run3_done_before", 32'(m_done), 32'd1);
    do_start();
    chk("run3_done_cleared", 32'(m_done), 32'd0);
    chk("run3_txn_cleared", 32'(m_txn), 32'd0);
    run_vecs(14, 21);
    wait_done(dt);
    chk("run3_txn", 32'(m_txn), 32'd8);
    chk("run3_err", 32'(m_err), 32'd1);
    chk("run3_perr", 32'(m_perr), 32'd0);

    // Run 4: stray ack while idle between cycles, then an error response
    sel_b = 1'b1;
    @(negedge clock);
    do_start();
    run_vecs(22, 23);
    chk("run4_mid_perr", 32'(m_perr), 32'd1);
    chk("run4_mid_err", 32'(m_err), 32'd1);
    chk("run4_mid_txn", 32'(m_txn), 32'd2);
    chk("run4_mid_busy", 32'(m_busy), 32'd1);
    run_vecs(24, 27);
    wait_done(dt);
    chk("run4_txn", 32'(m_txn), 32'd6);
    chk("run4_err", 32'(m_err), 32'd1);
    chk("run4_perr", 32'(m_perr), 32'd1);

    // Run 5: ack and err in the same cycle counts as one error
    sel_b = 1'b0;
    @(negedge clock);
    do_start();
    chk("run5_perr_cleared", 32'(m_perr), 32'd0);
    run_vecs(28, 35);
    wait_done(dt);
    chk("run5_txn", 32'(m_txn), 32'd8);
    chk("run5_err", 32'(m_err), 32'd1);
    chk("run5_perr", 32'(m_perr), 32'd1);

    // Timeout: no response, cycle held exactly 8 cycles
    @(negedge clock);
    do_start();
    n = 0;
    while (m_cyc && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("tmo_cyc_len", 32'(n), 32'd8);
    chk("tmo_flag", 32'(m_tmo), 32'd1);
    chk("tmo_done", 32'(m_done), 32'd1);
    chk("tmo_busy", 32'(m_busy), 32'd0);
    chk("tmo_txn", 32'(m_txn), 32'd0);

    // Reset during the third transaction, then a clean run from k=0
    @(negedge clock);
    do_start();
    run_vecs(0, 1);
    n = 0;
    while (!m_cyc && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("pre_rst_cyc", 32'(m_cyc), 32'd1);
    chk("pre_rst_adr", m_adr, 32'h0100_0002);
    chk("pre_rst_txn", 32'(m_txn), 32'd2);
    reset = 1'b1;
    @(negedge clock);
    chk_all_zero("midrst");
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_idle", 32'(m_cyc), 32'd0);
    do_start();
    run_vecs(0, 7);
    wait_done(dt);
    chk("rerun_cycles", dt, 32'd16);
    chk("rerun_txn", 32'(m_txn), 32'd8);
    chk("rerun_err", 32'(m_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
